// File: rtl/systolic_feeder_3x3_if.sv
// Load port and array-side operand/enable bundle for systolic_feeder_3x3.
// master = tile DMA / test driver side, slave = feeder.
interface systolic_feeder_3x3_if #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned MAC_ROW = 3,
  parameter int unsigned MAC_COL = 3
);
  logic                       start;
  logic [3:0]                 k_len;
  logic                       ld_valid;
  logic                       ld_sel;
  logic [MAC_ROW*DWIDTH-1:0]  ld_data;
  logic                       ld_ready;
  logic [DWIDTH-1:0]          a0, a1, a2;
  logic [DWIDTH-1:0]          b0, b1, b2;
  logic [MAC_ROW-1:0]         str_en;
  logic [MAC_ROW+MAC_COL-2:0] mul_en;
  logic [MAC_ROW*MAC_COL-1:0] pe_en;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, k_len, ld_valid, ld_sel, ld_data,
    input  ld_ready, a0, a1, a2, b0, b1, b2, str_en, mul_en, pe_en, busy, done, err
  );

  modport slave (
    input  start, k_len, ld_valid, ld_sel, ld_data,
    output ld_ready, a0, a1, a2, b0, b1, b2, str_en, mul_en, pe_en, busy, done, err
  );
endinterface

// File: rtl/systolic_feeder_3x3.sv
// Buffers one A (3xK) and one B (Kx3) tile, then replays them as diagonally
// skewed operand streams with per-row/per-PE/per-diagonal enables.
module systolic_feeder_3x3 #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MAC_ROW   = 3,
  parameter int unsigned MAC_COL   = 3,
  parameter int unsigned KMAX      = 8,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_feeder_3x3_if.slave bus
);
  localparam int unsigned NDIAG = MAC_ROW + MAC_COL - 1;
  localparam int unsigned CW    = $clog2(KMAX + NDIAG) + 1;
  localparam int unsigned KW    = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int unsigned DCW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_k, r_ka, r_kb, r_t;
  logic [DCW-1:0]             r_dc;
  logic [DWIDTH-1:0]          r_abuf [MAC_ROW][KMAX];
  logic [DWIDTH-1:0]          r_bbuf [KMAX][MAC_COL];
  logic [DWIDTH-1:0]          r_a [MAC_ROW];
  logic [DWIDTH-1:0]          r_b [MAC_COL];
  logic [MAC_ROW-1:0]         r_str;
  logic [NDIAG-1:0]           r_mul;
  logic [MAC_ROW*MAC_COL-1:0] r_pe;
  logic                       r_busy, r_done, r_err;

  logic                       w_ld_ready, w_accept, w_k_ok, w_full, w_t_last, w_stream_nxt;
  logic [CW-1:0]              w_tn, w_off;
  logic [DWIDTH-1:0]          w_a [MAC_ROW];
  logic [DWIDTH-1:0]          w_b [MAC_COL];
  logic [MAC_ROW-1:0]         w_str;
  logic [NDIAG-1:0]           w_mul;
  logic [MAC_ROW*MAC_COL-1:0] w_pe;

  always_comb begin
    w_ld_ready = 1'b0;
    if (r_state == S_LOAD) w_ld_ready = bus.ld_sel ? (r_kb < r_k) : (r_ka < r_k);
  end

  assign w_accept     = bus.ld_valid & w_ld_ready;
  assign w_k_ok       = (bus.k_len != '0) && (32'(bus.k_len) <= KMAX);
  assign w_full       = (r_ka == r_k) && (r_kb == r_k);
  assign w_t_last     = (r_t == r_k + CW'(NDIAG - 1) - CW'(1));
  assign w_stream_nxt = ((r_state == S_LOAD) && w_full) || ((r_state == S_STREAM) && !w_t_last);
  assign w_tn         = (r_state == S_STREAM) ? r_t + CW'(1) : '0;

  // Outputs are registered, so the skew pattern is evaluated for the t of the next cycle.
  always_comb begin
    w_str = '0;
    w_pe  = '0;
    w_mul = '0;
    w_off = '0;
    for (int unsigned r = 0; r < MAC_ROW; r++) begin
      w_a[r] = '0;
      w_off  = w_tn - CW'(r);
      if ((w_tn >= CW'(r)) && (w_off < r_k)) begin
        w_str[r] = 1'b1;
        w_a[r]   = r_abuf[r][w_off[KW-1:0]];
      end
    end
    for (int unsigned c = 0; c < MAC_COL; c++) begin
      w_b[c] = '0;
      w_off  = w_tn - CW'(c);
      if ((w_tn >= CW'(c)) && (w_off < r_k)) w_b[c] = r_bbuf[w_off[KW-1:0]][c];
    end
    for (int unsigned r = 0; r < MAC_ROW; r++) begin
      for (int unsigned c = 0; c < MAC_COL; c++) begin
        w_off = w_tn - CW'(r + c);
        if ((w_tn >= CW'(r + c)) && (w_off < r_k)) begin
          w_pe[r*MAC_COL+c] = 1'b1;
          w_mul[r+c]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (!bus.ld_sel) begin
        for (int unsigned r = 0; r < MAC_ROW; r++)
          r_abuf[r][r_ka[KW-1:0]] <= bus.ld_data[r*DWIDTH +: DWIDTH];
      end else begin
        for (int unsigned c = 0; c < MAC_COL; c++)
          r_bbuf[r_kb[KW-1:0]][c] <= bus.ld_data[c*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_ka    <= '0;
      r_kb    <= '0;
      r_t     <= '0;
      r_dc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_str   <= '0;
      r_mul   <= '0;
      r_pe    <= '0;
      for (int unsigned r = 0; r < MAC_ROW; r++) r_a[r] <= '0;
      for (int unsigned c = 0; c < MAC_COL; c++) r_b[c] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_str  <= w_stream_nxt ? w_str : '0;
      r_mul  <= w_stream_nxt ? w_mul : '0;
      r_pe   <= w_stream_nxt ? w_pe  : '0;
      for (int unsigned r = 0; r < MAC_ROW; r++) r_a[r] <= w_stream_nxt ? w_a[r] : '0;
      for (int unsigned c = 0; c < MAC_COL; c++) r_b[c] <= w_stream_nxt ? w_b[c] : '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_k_ok) begin
              r_k     <= CW'(bus.k_len);
              r_ka    <= '0;
              r_kb    <= '0;
              r_busy  <= 1'b1;
              r_state <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept && !bus.ld_sel) r_ka <= r_ka + CW'(1);
          if (w_accept &&  bus.ld_sel) r_kb <= r_kb + CW'(1);
          if (w_full) begin
            r_t     <= '0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          r_t <= w_tn;
          if (w_t_last) begin
            r_dc    <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // done cycle is already IDLE so a start presented alongside done is taken
          if (r_dc == DCW'(DRAIN_CYC - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_dc <= r_dc + DCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ready = w_ld_ready;
  assign bus.a0       = r_a[0];
  assign bus.a1       = r_a[1];
  assign bus.a2       = r_a[2];
  assign bus.b0       = r_b[0];
  assign bus.b1       = r_b[1];
  assign bus.b2       = r_b[2];
  assign bus.str_en   = r_str;
  assign bus.mul_en   = r_mul;
  assign bus.pe_en    = r_pe;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
endmodule
